alu_microprocessor: RTL and testbench

// - 32-bit registered ALU of the single-cycle microprocessor datapath.
// - Executes one of 16 operations, selected by alu_ctrl, on in_1/in_2.
// - Registers the result and ARM-style NZCV flags on each alu_clk rising edge.
// - Stored C flag feeds carry-in of ADC/SBC.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shifter.sv | 45 ++++
 rtl/alu_microprocessor.sv | 116 +++++++++++
 tb/tb_alu_microprocessor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and shifter-select definitions for the datapath ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORR = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_BIC = 4'h5;
  localparam logic [3:0] OP_LSL = 4'h6;
  localparam logic [3:0] OP_LSR = 4'h7;
  localparam logic [3:0] OP_ASR = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_SBC = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_RSB = 4'hD;
  localparam logic [3:0] OP_MOV = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter (LSL/LSR/ASR/ROR) with last-bit-out carry.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] sh_in,
  input  logic [4:0]  sh_amt,
  input  shift_op_e   sh_op,
  output logic [31:0] sh_rslt,
  output logic        sh_carry,
  output logic        sh_zero
);

  logic [32:0]        lsl_ext;
  logic [32:0]        lsr_ext;
  logic signed [32:0] asr_ext;
  logic [31:0]        ror_val;

  // Shifting through a 33-bit extension leaves the last bit shifted out in the spare bit.
  always_comb begin
    lsl_ext  = {1'b0, sh_in} << sh_amt;
    lsr_ext  = {sh_in, 1'b0} >> sh_amt;
    asr_ext  = $signed({sh_in, 1'b0}) >>> sh_amt;
    ror_val  = (sh_in >> sh_amt) | (sh_in << (6'd32 - {1'b0, sh_amt}));
    sh_rslt  = lsl_ext[31:0];
    sh_carry = lsl_ext[32];
    case (sh_op)
      SH_LSR: begin
        sh_rslt  = lsr_ext[32:1];
        sh_carry = lsr_ext[0];
      end
      SH_ASR: begin
        sh_rslt  = asr_ext[32:1];
        sh_carry = asr_ext[0];
      end
      SH_ROR: begin
        sh_rslt  = ror_val;
        sh_carry = ror_val[31];
      end
      default: ;
    endcase
  end

  assign sh_zero = (sh_amt == 5'd0);

endmodule

// File: rtl/alu_microprocessor.sv
// Registered 32-bit ALU: 16 operations, ARM-style NZCV flags, stored carry feeds ADC/SBC.
module alu_microprocessor
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] alu_rslt,
  output logic [3:0]       alu_checks
);

  logic             c_q;
  logic             v_q;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;
  shift_op_e        sh_op;
  logic [WIDTH-1:0] sh_rslt;
  logic             sh_carry;
  logic             sh_zero;
  logic [WIDTH-1:0] rslt_d;
  logic             c_d;
  logic             v_d;

  assign c_q = alu_checks[FLG_C];
  assign v_q = alu_checks[FLG_V];

  // Every subtract form becomes x + ~y + cin, so the adder carry-out is already NOT-borrow.
  always_comb begin
    add_x   = in_1;
    add_y   = in_2;
    add_cin = 1'b0;
    case (alu_ctrl)
      OP_SUB: begin
        add_y   = ~in_2;
        add_cin = 1'b1;
      end
      OP_ADC: add_cin = c_q;
      OP_SBC: begin
        add_y   = ~in_2;
        add_cin = c_q;
      end
      OP_RSB: begin
        add_x   = in_2;
        add_y   = ~in_1;
        add_cin = 1'b1;
      end
      default: ;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
  end

  always_comb begin
    case (alu_ctrl)
      OP_LSR:  sh_op = SH_LSR;
      OP_ASR:  sh_op = SH_ASR;
      OP_ROR:  sh_op = SH_ROR;
      default: sh_op = SH_LSL;
    endcase
  end

  alu_shifter u_shifter (
    .sh_in    (in_1),
    .sh_amt   (in_2[4:0]),
    .sh_op    (sh_op),
    .sh_rslt  (sh_rslt),
    .sh_carry (sh_carry),
    .sh_zero  (sh_zero)
  );

  always_comb begin
    rslt_d = add_sum[WIDTH-1:0];
    c_d    = c_q;
    v_d    = v_q;
    case (alu_ctrl)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_RSB: begin
        c_d = add_sum[WIDTH];
        v_d = add_v;
      end
      OP_AND: rslt_d = in_1 & in_2;
      OP_ORR: rslt_d = in_1 | in_2;
      OP_EOR: rslt_d = in_1 ^ in_2;
      OP_BIC: rslt_d = in_1 & ~in_2;
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        if (sh_zero) begin
          rslt_d = in_1;
        end else begin
          rslt_d = sh_rslt;
          c_d    = sh_carry;
        end
      end
      OP_MUL: rslt_d = in_1 * in_2;
      OP_MOV: rslt_d = in_2;
      OP_MVN: rslt_d = ~in_2;
      default: ;
    endcase
  end

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      alu_rslt   <= '0;
      alu_checks <= 4'b0000;
    end else begin
      alu_rslt   <= rslt_d;
      alu_checks <= {rslt_d[WIDTH-1], (rslt_d == '0), c_d, v_d};
    end
  end

endmodule

// File: tb/tb_alu_microprocessor.sv
// Scoreboard bench for alu_microprocessor: directed hand-computed vectors, then random vs a bit-level model.
module tb_alu_microprocessor;

  logic        alu_clk = 1'b0;
  logic        alu_rst_n = 1'b0;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] in_1 = '0;
  logic [31:0] in_2 = '0;
  logic [31:0] alu_rslt;
  logic [3:0]  alu_checks;

  typedef struct {
    logic [31:0] rslt;
    logic [3:0]  flags;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rslt;
    logic [3:0]  flags;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  logic issue = 1'b0;
  logic mon_on = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] model_flags;

  alu_microprocessor #(.WIDTH(32)) dut (
    .alu_clk    (alu_clk),
    .alu_rst_n  (alu_rst_n),
    .alu_ctrl   (alu_ctrl),
    .in_1       (in_1),
    .in_2       (in_2),
    .alu_rslt   (alu_rslt),
    .alu_checks (alu_checks)
  );

  always #5 alu_clk = ~alu_clk;

  function automatic longint sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference: arithmetic in 64 bits, shifts one bit at a time.
  function automatic void ref_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fin, output logic [31:0] r, output logic [3:0] fout);
    logic [63:0] wide;
    logic c, v, cin;
    int   sh;
    c   = fin[1];
    v   = fin[0];
    cin = fin[1];
    sh  = int'(b[4:0]);
    r   = '0;
    case (ctrl)
      4'h0, 4'hA: begin
        wide = {32'd0, a} + {32'd0, b} + ((ctrl == 4'hA) ? 64'(cin) : 64'd0);
        r = wide[31:0];
        c = wide[32];
        v = ovf(sx(a) + sx(b) + ((ctrl == 4'hA) ? longint'(cin) : 64'sd0));
      end
      4'h1, 4'hB: begin
        wide = {32'd0, b} + ((ctrl == 4'hB) ? 64'(!cin) : 64'd0);
        r = a - wide[31:0];
        c = ({32'd0, a} >= wide);
        v = ovf(sx(a) - sx(b) - ((ctrl == 4'hB) ? longint'(!cin) : 64'sd0));
      end
      4'hD: begin
        r = b - a;
        c = (b >= a);
        v = ovf(sx(b) - sx(a));
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a & ~b;
      4'h6, 4'h7, 4'h8, 4'h9: begin
        r = a;
        for (int i = 0; i < sh; i++) begin
          case (ctrl)
            4'h6: begin c = r[31]; r = {r[30:0], 1'b0}; end
            4'h7: begin c = r[0];  r = {1'b0, r[31:1]}; end
            4'h8: begin c = r[0];  r = {r[31], r[31:1]}; end
            default: begin c = r[0]; r = {r[0], r[31:1]}; end
          endcase
        end
      end
      4'hC: begin
        wide = {32'd0, a} * {32'd0, b};
        r = wide[31:0];
      end
      4'hE: r = b;
      default: r = ~b;
    endcase
    fout = {r[31], (r == 32'd0), c, v};
  endfunction

  task automatic drive(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input string nm);
    exp_t e;
    @(negedge alu_clk);
    alu_ctrl = ctrl;
    in_1     = a;
    in_2     = b;
    issue    = 1'b1;
    e.rslt   = er;
    e.flags  = ef;
    e.name   = nm;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    @(negedge alu_clk);
    issue  = 1'b0;
    budget = 10;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge alu_clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every edge that captured an issued op must match the head of the scoreboard.
  initial begin
    logic iss;
    exp_t e;
    forever begin
      @(posedge alu_clk);
      iss = issue;
      #1;
      if (iss && mon_on) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL %s: output with empty scoreboard, rslt=%h nzcv=%b", "no_expect", alu_rslt, alu_checks);
        end else begin
          e = sb_q.pop_front();
          if (alu_rslt !== e.rslt || alu_checks !== e.flags) begin
            n_err++;
            $display("FAIL %s: got rslt=%h nzcv=%b, required rslt=%h nzcv=%b",
                     e.name, alu_rslt, alu_checks, e.rslt, e.flags);
          end
        end
      end
    end
  end

  vec_t dir[16];

  initial begin
    logic [3:0]  ctrl;
    logic [31:0] a, b, er;
    logic [3:0]  ef;

    dir[0]  = '{4'h0, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, "add_1_1"};
    dir[1]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, "add_wrap"};
    dir[2]  = '{4'hA, 32'h00000000, 32'h00000000, 32'h00000001, 4'b0000, "adc_cin1"};
    dir[3]  = '{4'h1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1001, "sub_ovf"};
    dir[4]  = '{4'h6, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0011, "lsl_1"};
    dir[5]  = '{4'h9, 32'h80000001, 32'h00000000, 32'h80000001, 4'b1011, "ror_0"};
    dir[6]  = '{4'hB, 32'h00000005, 32'h00000003, 32'h00000002, 4'b0010, "sbc_c1"};
    dir[7]  = '{4'hD, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 4'b1000, "rsb_borrow"};
    dir[8]  = '{4'hC, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0100, "mul_wrap"};
    dir[9]  = '{4'hB, 32'h00000005, 32'h00000003, 32'h00000001, 4'b0010, "sbc_c0"};
    dir[10] = '{4'h8, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b1000, "asr_31"};
    dir[11] = '{4'h7, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0010, "lsr_1"};
    dir[12] = '{4'hF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1010, "mvn_0"};
    dir[13] = '{4'h5, 32'h000000FF, 32'h0000000F, 32'h000000F0, 4'b0010, "bic"};
    dir[14] = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, "add_ovf"};
    dir[15] = '{4'h6, 32'h00000001, 32'h00000020, 32'h00000001, 4'b0001, "lsl_sh32"};

    repeat (2) @(negedge alu_clk);
    alu_rst_n = 1'b1;

    drive(4'hE, 32'h0, 32'h80001234, 32'h80001234, 4'b1000, "mov_pre_rst");
    drain();
    #2;
    alu_rst_n = 1'b0;
    #1;
    n_vec++;
    if (alu_rslt !== 32'h0 || alu_checks !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: got rslt=%h nzcv=%b, required rslt=00000000 nzcv=0000", alu_rslt, alu_checks);
    end
    @(negedge alu_clk);
    alu_rst_n = 1'b1;

    foreach (dir[i]) drive(dir[i].ctrl, dir[i].a, dir[i].b, dir[i].rslt, dir[i].flags, dir[i].name);
    drain();
    model_flags = dir[15].flags;

    for (int n = 0; n < 10000; n++) begin
      ctrl = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'(b[4:0]);
        1: a = 32'hFFFFFFFF;
        2: b = a;
        default: ;
      endcase
      ref_alu(ctrl, a, b, model_flags, er, ef);
      model_flags = ef;
      drive(ctrl, a, b, er, ef, "random");
    end
    drain();

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
